// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-master RAM arbiter: FSM state encoding,
// master indices and default geometry.
package ram_arb_pkg;

  localparam int ADDR_W_DEF    = 10;
  localparam int DATA_W_DEF    = 32;
  localparam int MAX_BURST_DEF = 4;

  localparam int M_CPU = 0;
  localparam int M_AUX = 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    OWN0 = ST_OWN0,
    OWN1 = ST_OWN1
  } arb_state_e;

endpackage

// File: rtl/ram_arbiter_pick.sv
// Two-way tie-break: a lone requester wins outright; on a tie the pointer
// names the favoured master (0 = CPU, 1 = AUX).
module arb_rr_pick
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] pick
);

  always_comb begin
    pick = 2'b00;
    if (req[M_CPU] && req[M_AUX]) begin
      pick[M_AUX] = ptr;
      pick[M_CPU] = ~ptr;
    end else begin
      pick = req;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter for a single-port data RAM with lockable bursts.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed priority to master 0.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_i,
  input  logic [1:0]            lock_i,
  input  logic [2*DATA_W/8-1:0] we_i,
  input  logic [2*ADDR_W-1:0]   addr_i,
  input  logic [2*DATA_W-1:0]   wdata_i,
  output logic [1:0]            gnt_o,
  output logic [1:0]            rvalid_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic [ADDR_W-1:0]     ram_addr_o,
  output logic [DATA_W/8-1:0]   ram_wea_o,
  output logic [DATA_W-1:0]     ram_dina_o,
  input  logic [DATA_W-1:0]     ram_douta_i
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] burst_cnt;
  logic [1:0]       rvalid_q;
  logic [1:0]       own_mask;
  logic [1:0]       cand;
  logic [1:0]       pick;
  logic             at_limit;
  logic             keep;
  logic             ptr;

  logic [BE_W-1:0]   we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;

  assign we0    = we_i[BE_W-1:0];
  assign we1    = we_i[2*BE_W-1:BE_W];
  assign addr0  = addr_i[ADDR_W-1:0];
  assign addr1  = addr_i[2*ADDR_W-1:ADDR_W];
  assign wdata0 = wdata_i[DATA_W-1:0];
  assign wdata1 = wdata_i[2*DATA_W-1:DATA_W];

  assign own_mask = (state == ST_OWN0) ? 2'b01 :
                    (state == ST_OWN1) ? 2'b10 : 2'b00;
  assign at_limit = (burst_cnt >= CNT_W'(MAX_BURST));

  // The owner keeps the RAM unless a competitor has waited out a full burst.
  assign keep = (|(req_i & own_mask)) && !((|(req_i & ~own_mask)) && at_limit);
  assign cand = req_i & ~own_mask;

  arb_rr_pick u_pick (
    .req  (cand),
    .ptr  (ptr),
    .pick (pick)
  );

  assign gnt_o = rst ? 2'b00 : (keep ? own_mask : pick);

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic ptr_q;
  assign ptr = ptr_q;

  // After a fresh grant the other master becomes favoured for the next tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if ((|gnt_o) && !keep) begin
      ptr_q <= gnt_o[M_CPU];
    end
  end
`else
  assign ptr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      burst_cnt <= '0;
      rvalid_q  <= 2'b00;
    end else begin
      rvalid_q[M_CPU] <= gnt_o[M_CPU] && (we0 == '0);
      rvalid_q[M_AUX] <= gnt_o[M_AUX] && (we1 == '0);
      if (|(gnt_o & lock_i)) begin
        state <= gnt_o[M_AUX] ? ST_OWN1 : ST_OWN0;
        if (!keep) begin
          burst_cnt <= CNT_W'(1);
        end else if (!at_limit) begin
          burst_cnt <= burst_cnt + 1'b1;
        end
      end else begin
        state     <= ST_IDLE;
        burst_cnt <= '0;
      end
    end
  end

  always_comb begin
    ram_addr_o = '0;
    ram_wea_o  = '0;
    ram_dina_o = '0;
    if (gnt_o[M_AUX]) begin
      ram_addr_o = addr1;
      ram_wea_o  = we1;
      ram_dina_o = wdata1;
    end else if (gnt_o[M_CPU]) begin
      ram_addr_o = addr0;
      ram_wea_o  = we0;
      ram_dina_o = wdata0;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = ram_douta_i;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural one-cycle-latency RAM.
// Expectations follow RAM_ARB_ROUND_ROBIN_EN when the bench is built with it.
module tb_ram_arbiter;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, lock;
  logic [3:0]  we0, we1;
  logic [9:0]  a0, a1;
  logic [31:0] d0, d1;
  logic [7:0]  we_i;
  logic [19:0] addr_i;
  logic [63:0] wdata_i;
  logic [1:0]  gnt_o, rvalid_o;
  logic [31:0] rdata_o, ram_dina_o, ram_douta;
  logic [9:0]  ram_addr_o;
  logic [3:0]  ram_wea_o;
  logic [31:0] mem [0:1023];

  int n_vec = 0;
  int n_bad = 0;

  assign we_i    = {we1, we0};
  assign addr_i  = {a1, a0};
  assign wdata_i = {d1, d0};

  ram_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .lock_i      (lock),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .ram_addr_o  (ram_addr_o),
    .ram_wea_o   (ram_wea_o),
    .ram_dina_o  (ram_dina_o),
    .ram_douta_i (ram_douta)
  );

  always #5 clk = ~clk;

  // Read-first RAM with byte enables and one cycle of read latency.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_wea_o[b]) mem[ram_addr_o][b*8 +: 8] <= ram_dina_o[b*8 +: 8];
    end
    ram_douta <= mem[ram_addr_o];
  end

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  lock;
    logic [3:0]  we0;
    logic [9:0]  a0;
    logic [31:0] d0;
    logic [3:0]  we1;
    logic [9:0]  a1;
    logic [1:0]  gnt;
    logic [3:0]  wea;
    logic [9:0]  addr;
    logic [1:0]  rvalid;
    logic        chk_rd;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [16];

  task automatic applyStimulus(input logic r, input logic [1:0] rq, input logic [1:0] lk,
                               input logic [3:0] w0, input logic [9:0] ad0, input logic [31:0] wd0,
                               input logic [3:0] w1, input logic [9:0] ad1);
    @(negedge clk);
    rst = r; req = rq; lock = lk;
    we0 = w0; a0 = ad0; d0 = wd0;
    we1 = w1; a1 = ad1; d1 = 32'hA5A5_A5A5;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic stepCheck(input string name, input logic r, input logic [1:0] rq, input logic [1:0] lk,
                           input logic [1:0] exp_gnt, input logic [1:0] exp_rv);
    applyStimulus(r, rq, lk, 4'h0, 10'h008, 32'h0, 4'h0, 10'h009);
    checkOutput({name, " gnt"}, 32'(gnt_o), 32'(exp_gnt));
    checkOutput({name, " rvalid"}, 32'(rvalid_o), 32'(exp_rv));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[10'h005] = 32'hDEAD_BEEF;
    mem[10'h007] = 32'hCAFE_F00D;

    // Fields: rst req lock we0 a0 d0 we1 a1 | gnt wea addr rvalid chk_rd rdata
    vecs[0]  = '{1'b1, 2'b11, 2'b11, 4'hF, 10'h003, 32'h0, 4'h0, 10'h004, 2'b00, 4'h0, 10'h000, 2'b00, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 2'b00, 2'b00, 4'h0, 10'h003, 32'h0, 4'h0, 10'h004, 2'b00, 4'h0, 10'h000, 2'b00, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 2'b11, 2'b00, 4'h0, 10'h001, 32'h0, 4'h0, 10'h002, 2'b01, 4'h0, 10'h001, 2'b00, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 2'b11, 2'b00, 4'h0, 10'h001, 32'h0, 4'h0, 10'h002,
                 RR ? 2'b10 : 2'b01, 4'h0, RR ? 10'h002 : 10'h001, 2'b01, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 2'b11, 2'b00, 4'h0, 10'h001, 32'h0, 4'h0, 10'h002,
                 2'b01, 4'h0, 10'h001, RR ? 2'b10 : 2'b01, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 2'b11, 2'b00, 4'h0, 10'h001, 32'h0, 4'h0, 10'h002,
                 RR ? 2'b10 : 2'b01, 4'h0, RR ? 10'h002 : 10'h001, 2'b01, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 2'b00, 2'b00, 4'h0, 10'h001, 32'h0, 4'h0, 10'h002,
                 2'b00, 4'h0, 10'h000, RR ? 2'b10 : 2'b01, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 2'b10, 2'b00, 4'h0, 10'h000, 32'h0, 4'h0, 10'h005, 2'b10, 4'h0, 10'h005, 2'b00, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 2'b00, 2'b00, 4'h0, 10'h000, 32'h0, 4'h0, 10'h000, 2'b00, 4'h0, 10'h000, 2'b10, 1'b1, 32'hDEAD_BEEF};
    vecs[9]  = '{1'b0, 2'b01, 2'b00, 4'h3, 10'h3FF, 32'h1234_5678, 4'h0, 10'h000, 2'b01, 4'h3, 10'h3FF, 2'b00, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 2'b00, 2'b00, 4'h0, 10'h000, 32'h0, 4'h0, 10'h000, 2'b00, 4'h0, 10'h000, 2'b00, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 2'b01, 2'b00, 4'h0, 10'h3FF, 32'h0, 4'h0, 10'h000, 2'b01, 4'h0, 10'h3FF, 2'b00, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 2'b00, 2'b00, 4'h0, 10'h000, 32'h0, 4'h0, 10'h000, 2'b00, 4'h0, 10'h000, 2'b01, 1'b1, 32'h0000_5678};
    vecs[13] = '{1'b0, 2'b01, 2'b00, 4'h0, 10'h005, 32'h0, 4'h0, 10'h000, 2'b01, 4'h0, 10'h005, 2'b00, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 2'b10, 2'b00, 4'h0, 10'h000, 32'h0, 4'h0, 10'h007, 2'b10, 4'h0, 10'h007, 2'b01, 1'b1, 32'hDEAD_BEEF};
    vecs[15] = '{1'b0, 2'b00, 2'b00, 4'h0, 10'h000, 32'h0, 4'h0, 10'h000, 2'b00, 4'h0, 10'h000, 2'b10, 1'b1, 32'hCAFE_F00D};

    rst = 1'b1; req = 2'b00; lock = 2'b00;
    we0 = 4'h0; we1 = 4'h0; a0 = 10'h0; a1 = 10'h0; d0 = 32'h0; d1 = 32'h0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].lock, vecs[i].we0, vecs[i].a0, vecs[i].d0,
                    vecs[i].we1, vecs[i].a1);
      checkOutput($sformatf("v%0d gnt", i), 32'(gnt_o), 32'(vecs[i].gnt));
      checkOutput($sformatf("v%0d wea", i), 32'(ram_wea_o), 32'(vecs[i].wea));
      checkOutput($sformatf("v%0d addr", i), 32'(ram_addr_o), 32'(vecs[i].addr));
      checkOutput($sformatf("v%0d rvalid", i), 32'(rvalid_o), 32'(vecs[i].rvalid));
      if (vecs[i].chk_rd) checkOutput($sformatf("v%0d rdata", i), rdata_o, vecs[i].rdata);
    end

    // Locked burst by master 0 against a waiting master 1: forced rotation at cycle 4.
    for (int c = 0; c < 4; c++)
      stepCheck($sformatf("burst%0d", c), 1'b0, 2'b11, 2'b01, 2'b01, (c == 0) ? 2'b00 : 2'b01);
    stepCheck("burst4", 1'b0, 2'b11, 2'b01, 2'b10, 2'b01);
    stepCheck("burst5", 1'b0, 2'b00, 2'b00, 2'b00, 2'b10);

    // Uncontested lock holds indefinitely; the saturated count forces release once 1 arrives.
    for (int c = 0; c < 7; c++)
      stepCheck($sformatf("sat%0d", c), 1'b0, 2'b01, 2'b01, 2'b01, (c == 0) ? 2'b00 : 2'b01);
    stepCheck("sat7", 1'b0, 2'b11, 2'b01, 2'b10, 2'b01);

    // Owner drops its request: the other master is served in the same cycle.
    stepCheck("drop0", 1'b0, 2'b10, 2'b10, 2'b10, 2'b10);
    stepCheck("drop1", 1'b0, 2'b01, 2'b00, 2'b01, 2'b10);

    // Reset in the middle of an OWN1 read burst.
    stepCheck("rst0", 1'b0, 2'b10, 2'b10, 2'b10, 2'b01);
    stepCheck("rst1", 1'b0, 2'b10, 2'b10, 2'b10, 2'b10);
    stepCheck("rst2", 1'b1, 2'b10, 2'b10, 2'b00, 2'b10);
    checkOutput("rst2 addr", 32'(ram_addr_o), 32'h0);
    checkOutput("rst2 wea", 32'(ram_wea_o), 32'h0);
    stepCheck("rst3", 1'b0, 2'b11, 2'b00, 2'b01, 2'b00);
    stepCheck("rst4", 1'b0, 2'b00, 2'b00, 2'b00, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
